// File: rtl/req_gnt_responder.sv
// req_gnt_responder: grant-side responder for the single-cycle req/gnt handshake.
// Each accepted request travels down a GNT_LAT-1 stage valid shift line and
// leaves through the registered gnt output, GNT_LAT edges after acceptance.
// Optional feature macro: REQ_TAG_EN carries req_tag down the line to gnt_tag.
// Without it the tag input is ignored and gnt_tag is tied to zero.
module req_gnt_responder #(
  parameter int GNT_LAT = 3,
  parameter int MAX_OUT = 2,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             req_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             gnt_o,
  output logic [TAG_W-1:0] gnt_tag_o,
  output logic             drop_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] gnt_cnt_o
);

  localparam int STAGES = GNT_LAT - 1;
  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_C = OUT_W'(MAX_OUT);

  logic [STAGES-1:0] vld_q, vld_d;
  logic              gnt_q, gnt_d;
  logic              drop_q, drop_d;
  logic              busy_q, busy_d;
  logic [OUT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  gnt_cnt_q, gnt_cnt_d;
  logic              slot_free;
  logic              accept;

  // Admission, shift line advance, in-flight bookkeeping and grant counting.
  // A grant leaving at this edge frees its slot for a request arriving at the
  // same edge, so a full pipeline can still stream one request per cycle.
  always_comb begin
    slot_free = (cnt_q < MAX_C) || gnt_q;
    accept    = en_i && req_i && slot_free;
    drop_d    = en_i && req_i && !slot_free;

    vld_d    = '0;
    vld_d[0] = accept;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    gnt_d = vld_q[STAGES-1];

    cnt_d = cnt_q;
    case ({accept, gnt_q})
      2'b10:   cnt_d = cnt_q + OUT_W'(1);
      2'b01:   cnt_d = cnt_q - OUT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    busy_d = (cnt_d != '0);

    gnt_cnt_d = gnt_cnt_q;
    if (gnt_d && (gnt_cnt_q != '1)) begin
      gnt_cnt_d = gnt_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards everything in flight, including a req seen this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q     <= '0;
      gnt_q     <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      gnt_cnt_q <= '0;
    end else begin
      vld_q     <= vld_d;
      gnt_q     <= gnt_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

`ifdef REQ_TAG_EN
  logic [TAG_W-1:0] tag_q [STAGES];
  logic [TAG_W-1:0] tag_d [STAGES];
  logic [TAG_W-1:0] gnt_tag_q, gnt_tag_d;

  // Tags ride alongside the valid bits; an empty stage carries zero.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      tag_d[i] = '0;
    end
    tag_d[0] = accept ? req_tag_i : '0;
    for (int i = 1; i < STAGES; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    gnt_tag_d = vld_q[STAGES-1] ? tag_q[STAGES-1] : '0;
  end

  // Tag registers, cleared together with the valid line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
      gnt_tag_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= tag_d[i];
      end
      gnt_tag_q <= gnt_tag_d;
    end
  end

  assign gnt_tag_o = gnt_tag_q;
`else
  logic unused_req_tag;
  assign unused_req_tag = ^req_tag_i;
  assign gnt_tag_o      = '0;
`endif

  assign gnt_o     = gnt_q;
  assign drop_o    = drop_q;
  assign busy_o    = busy_q;
  assign gnt_cnt_o = gnt_cnt_q;

endmodule

// File: tb/tb_req_gnt_responder.sv
// Directed bench for req_gnt_responder. Three instances share the inputs:
// the default configuration, a MAX_OUT=3 copy for streaming, and a MAX_OUT=3
// copy with a 2-bit grant counter to reach saturation.
module tb_req_gnt_responder;

   logic       clk;
   logic       rst;
   logic       en;
   logic       req;
   logic [3:0] reqTag;

   logic        gnt,  drop,  busy;
   logic [3:0]  gntTag;
   logic [15:0] gntCnt;
   logic        gnt3, drop3, busy3;
   logic [3:0]  gntTag3;
   logic [15:0] gntCnt3;
   logic        gntS, dropS, busyS;
   logic [3:0]  gntTagS;
   logic [1:0]  gntCntS;

   int vectors;
   int miscompares;

   req_gnt_responder dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .req_tag_i(reqTag),
      .gnt_o(gnt), .gnt_tag_o(gntTag), .drop_o(drop), .busy_o(busy), .gnt_cnt_o(gntCnt)
   );

   req_gnt_responder #(.GNT_LAT(3), .MAX_OUT(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .req_tag_i(reqTag),
      .gnt_o(gnt3), .gnt_tag_o(gntTag3), .drop_o(drop3), .busy_o(busy3), .gnt_cnt_o(gntCnt3)
   );

   req_gnt_responder #(.GNT_LAT(3), .MAX_OUT(3), .CNT_W(2)) dutS (
      .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .req_tag_i(reqTag),
      .gnt_o(gntS), .gnt_tag_o(gntTagS), .drop_o(dropS), .busy_o(busyS), .gnt_cnt_o(gntCntS)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one edge worth of inputs; on return the outputs show what the
   // following edge samples.
   task automatic applyStimulus(input logic r, input logic e, input logic q, input logic [3:0] t);
      rst    = r;
      en     = e;
      req    = q;
      reqTag = t;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
      end
   endtask

   // Directed sequence; comments give the edge number each applyStimulus represents
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b0; en = 1'b0; req = 1'b0; reqTag = 4'h0;

      // Single request: req at edge 2, gnt sampled at edge 5 only
      applyStimulus(1, 0, 0, 0);                 // edge 1
      checkOutput("reset_gnt",    gnt,    0);
      checkOutput("reset_drop",   drop,   0);
      checkOutput("reset_busy",   busy,   0);
      checkOutput("reset_cnt",    gntCnt, 0);
      checkOutput("reset_tag",    gntTag, 0);
      applyStimulus(0, 1, 1, 0);                 // edge 2
      checkOutput("single_gnt3",  gnt,  0);
      checkOutput("single_busy3", busy, 1);
      applyStimulus(0, 1, 0, 0);                 // edge 3
      checkOutput("single_gnt4",  gnt,  0);
      applyStimulus(0, 1, 0, 0);                 // edge 4
      checkOutput("single_gnt5",  gnt,  1);
      checkOutput("single_cnt5",  gntCnt, 1);
      checkOutput("single_busy5", busy, 1);
      applyStimulus(0, 1, 0, 0);                 // edge 5
      checkOutput("single_gnt6",  gnt,  0);
      checkOutput("single_busy6", busy, 0);
      checkOutput("single_cnt6",  gntCnt, 1);

      // Limit/drop with MAX_OUT=2: req at edges 2,3,4
      applyStimulus(1, 0, 0, 0);                 // edge 1
      applyStimulus(0, 1, 1, 0);                 // edge 2
      checkOutput("lim_busy3", busy, 1);
      checkOutput("lim_drop3", drop, 0);
      applyStimulus(0, 1, 1, 0);                 // edge 3
      checkOutput("lim_drop4", drop, 0);
      checkOutput("lim_gnt4",  gnt,  0);
      applyStimulus(0, 1, 1, 0);                 // edge 4
      checkOutput("lim_gnt5",  gnt,  1);
      checkOutput("lim_drop5", drop, 1);
      checkOutput("lim_busy5", busy, 1);
      applyStimulus(0, 1, 0, 0);                 // edge 5
      checkOutput("lim_gnt6",  gnt,  1);
      checkOutput("lim_drop6", drop, 0);
      checkOutput("lim_busy6", busy, 1);
      applyStimulus(0, 1, 0, 0);                 // edge 6
      checkOutput("lim_gnt7",  gnt,  0);
      checkOutput("lim_busy7", busy, 0);
      checkOutput("lim_cnt7",  gntCnt, 2);

      // Steady stream on MAX_OUT=3 copies: req at edges 2..9, gnt sampled at 5..12
      applyStimulus(1, 0, 0, 0);                 // edge 1
      for (int e = 2; e <= 13; e++) begin
         applyStimulus(0, 1, (e <= 9) ? 1'b1 : 1'b0, 0);
         checkOutput($sformatf("stream_gnt%0d", e + 1), gnt3, ((e + 1 >= 5) && (e + 1 <= 12)) ? 1 : 0);
         checkOutput($sformatf("stream_drop%0d", e + 1), drop3, 0);
      end
      checkOutput("stream_cnt",     gntCnt3, 8);
      checkOutput("stream_busy",    busy3,   0);
      checkOutput("stream_sat_cnt", gntCntS, 3);

      // Reset mid-flight: req at edge 2, rst at edge 3
      applyStimulus(1, 0, 0, 0);                 // edge 1
      applyStimulus(0, 1, 1, 0);                 // edge 2
      applyStimulus(1, 1, 0, 0);                 // edge 3
      checkOutput("rstmid_busy4", busy,   0);
      checkOutput("rstmid_cnt4",  gntCnt, 0);
      for (int e = 4; e <= 6; e++) begin
         applyStimulus(0, 1, 0, 0);
         checkOutput($sformatf("rstmid_gnt%0d", e + 1), gnt, 0);
      end

      // en low: req ignored silently
      applyStimulus(1, 0, 0, 0);                 // edge 1
      applyStimulus(0, 0, 1, 0);                 // edge 2
      checkOutput("enlow_busy3", busy, 0);
      for (int e = 3; e <= 5; e++) begin
         applyStimulus(0, 0, 0, 0);
         checkOutput($sformatf("enlow_gnt%0d", e + 1),  gnt,  0);
         checkOutput($sformatf("enlow_drop%0d", e + 1), drop, 0);
      end

      // Accepted req, then en dropped: grant still arrives on schedule
      applyStimulus(1, 0, 0, 0);                 // edge 1
      applyStimulus(0, 1, 1, 0);                 // edge 2
      applyStimulus(0, 0, 1, 0);                 // edge 3
      checkOutput("enoff_drop4", drop, 0);
      applyStimulus(0, 0, 1, 0);                 // edge 4
      checkOutput("enoff_gnt5",  gnt,  1);
      applyStimulus(0, 0, 1, 0);                 // edge 5
      checkOutput("enoff_gnt6",  gnt,  0);
      checkOutput("enoff_drop6", drop, 0);

      // Tags 0x3, 0x9 at edges 2,3
      applyStimulus(1, 0, 0, 0);                 // edge 1
      applyStimulus(0, 1, 1, 4'h3);              // edge 2
      checkOutput("tag3", gntTag, 0);
      applyStimulus(0, 1, 1, 4'h9);              // edge 3
      checkOutput("tag4", gntTag, 0);
      applyStimulus(0, 1, 0, 4'hf);              // edge 4
      checkOutput("tag_gnt5", gnt, 1);
`ifdef REQ_TAG_EN
      checkOutput("tag5", gntTag, 4'h3);
`else
      checkOutput("tag5", gntTag, 0);
`endif
      applyStimulus(0, 1, 0, 4'hf);              // edge 5
      checkOutput("tag_gnt6", gnt, 1);
`ifdef REQ_TAG_EN
      checkOutput("tag6", gntTag, 4'h9);
`else
      checkOutput("tag6", gntTag, 0);
`endif
      applyStimulus(0, 1, 0, 4'hf);              // edge 6
      checkOutput("tag7", gntTag, 0);
      checkOutput("tag_gnt7", gnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
